// File: rtl/fpu_pkg.sv
// Shared FPU constants and the state encoding for the iterative multiplier.
package fpu_pkg;

  localparam int BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Normalize, round-to-nearest-even and pack a 48-bit mantissa product into
// an IEEE-754 single, flushing underflow to signed zero.
module fp_round_pack
  import fpu_pkg::*;
(
  input  logic [47:0] prod,
  input  logic [7:0]  exp_a,
  input  logic [7:0]  exp_b,
  input  logic        sign,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  logic signed [9:0] exp_sum;
  logic signed [9:0] exp_norm;
  logic signed [9:0] exp_final;
  logic [22:0]       frac;
  logic [22:0]       frac_final;
  logic [23:0]       frac_inc;
  logic              guard;
  logic              sticky;
  logic              round_up;

  always_comb begin
    exp_sum    = 10'(exp_a) + 10'(exp_b) - 10'(BIAS);
    exp_norm   = exp_sum;
    frac       = prod[45:23];
    guard      = prod[22];
    sticky     = |prod[21:0];
    frac_inc   = 24'd0;
    round_up   = 1'b0;
    exp_final  = exp_sum;
    frac_final = 23'd0;
    result     = 32'd0;
    overflow   = 1'b0;
    underflow  = 1'b0;

    // A product in [2,4) sits one bit higher and bumps the exponent.
    if (prod[47]) begin
      frac     = prod[46:24];
      guard    = prod[23];
      sticky   = |prod[22:0];
      exp_norm = exp_sum + 10'sd1;
    end

    round_up  = guard & (sticky | frac[0]);
    frac_inc  = {1'b0, frac} + {23'd0, round_up};
    exp_final = exp_norm;
    if (frac_inc[23]) begin
      frac_final = 23'd0;
      exp_final  = exp_norm + 10'sd1;
    end else begin
      frac_final = frac_inc[22:0];
    end

    if (exp_final >= 10'(EXP_MAX)) begin
      result   = {sign, 8'hFF, 23'd0};
      overflow = 1'b1;
    end else if (exp_final <= 10'sd0) begin
      result    = {sign, 31'd0};
      underflow = 1'b1;
    end else begin
      result = {sign, exp_final[7:0], frac_final};
    end
  end

endmodule

// File: rtl/fp_mul_iter.sv
// Iterative single-precision multiplier: 24-step radix-2 shift-add mantissa
// product, then one normalize/round cycle; specials resolve straight from IDLE.
module fp_mul_iter
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signA_i,
  input  logic        signB_i,
  input  logic [7:0]  expA_i,
  input  logic [7:0]  expB_i,
  input  logic [23:0] mantA_i,
  input  logic [23:0] mantB_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        invalid_o
);

  state_t      state;
  logic [4:0]  cnt;
  logic [47:0] prod;
  logic [23:0] mant_a_q;
  logic [23:0] mult_b;
  logic [7:0]  exp_a_q;
  logic [7:0]  exp_b_q;
  logic        sign_q;

  logic [24:0] acc_sum;
  logic [31:0] rp_result;
  logic        rp_overflow;
  logic        rp_underflow;

  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        special;
  logic        sign_in;
  logic [31:0] spec_result;
  logic        spec_invalid;

  always_comb begin
    sign_in      = signA_i ^ signB_i;
    a_zero       = (expA_i == 8'd0);
    b_zero       = (expB_i == 8'd0);
    a_inf        = (expA_i == 8'(EXP_MAX)) && (mantA_i[22:0] == 23'd0);
    b_inf        = (expB_i == 8'(EXP_MAX)) && (mantB_i[22:0] == 23'd0);
    a_nan        = (expA_i == 8'(EXP_MAX)) && (mantA_i[22:0] != 23'd0);
    b_nan        = (expB_i == 8'(EXP_MAX)) && (mantB_i[22:0] != 23'd0);
    special      = a_zero | b_zero | (expA_i == 8'(EXP_MAX)) | (expB_i == 8'(EXP_MAX));
    spec_result  = {sign_in, 31'd0};
    spec_invalid = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_result  = QNAN;
      spec_invalid = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_result = {sign_in, 8'hFF, 23'd0};
    end
  end

  // Upper half accumulates the partial product; the whole register shifts right.
  assign acc_sum = {1'b0, prod[47:24]} + (mult_b[0] ? {1'b0, mant_a_q} : 25'd0);

  fp_round_pack u_round_pack (
    .prod      (prod),
    .exp_a     (exp_a_q),
    .exp_b     (exp_b_q),
    .sign      (sign_q),
    .result    (rp_result),
    .overflow  (rp_overflow),
    .underflow (rp_underflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      prod        <= 48'd0;
      mant_a_q    <= 24'd0;
      mult_b      <= 24'd0;
      exp_a_q     <= 8'd0;
      exp_b_q     <= 8'd0;
      sign_q      <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      result_o    <= 32'd0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      invalid_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            busy_o <= 1'b1;
            sign_q <= sign_in;
            if (special) begin
              state       <= DONE;
              done_o      <= 1'b1;
              result_o    <= spec_result;
              overflow_o  <= 1'b0;
              underflow_o <= 1'b0;
              invalid_o   <= spec_invalid;
            end else begin
              state    <= MUL;
              cnt      <= 5'd23;
              prod     <= 48'd0;
              mant_a_q <= mantA_i;
              mult_b   <= mantB_i;
              exp_a_q  <= expA_i;
              exp_b_q  <= expB_i;
            end
          end
        end
        MUL: begin
          prod   <= {acc_sum, prod[23:1]};
          mult_b <= {1'b0, mult_b[23:1]};
          if (cnt == 5'd0) state <= NORM;
          else             cnt   <= cnt - 5'd1;
        end
        NORM: begin
          state       <= DONE;
          done_o      <= 1'b1;
          result_o    <= rp_result;
          overflow_o  <= rp_overflow;
          underflow_o <= rp_underflow;
          invalid_o   <= 1'b0;
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Directed bench for fp_mul_iter with hand-computed products and latencies.
module tb_fp_mul_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signA_i, signB_i;
  logic [7:0]  expA_i, expB_i;
  logic [23:0] mantA_i, mantB_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic        overflow_o, underflow_o, invalid_o;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  bit saw_done;

  fp_mul_iter dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signA_i     (signA_i),
    .signB_i     (signB_i),
    .expA_i      (expA_i),
    .expB_i      (expB_i),
    .mantA_i     (mantA_i),
    .mantB_i     (mantB_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o),
    .invalid_o   (invalid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                         input logic sb, input logic [7:0] eb, input logic [23:0] mb);
    signA_i = sa; expA_i = ea; mantA_i = ma;
    signB_i = sb; expB_i = eb; mantB_i = mb;
  endtask

  // Pulse start for one edge, then count cycles until done_o is seen.
  task automatic run_op(output int latency);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    latency = 1;
    while (!done_o && latency < 100) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, overflow_o, underflow_o, invalid_o}, {29'd0, exp});
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0;
    set_ops(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 24'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",   {31'd0, busy_o}, 32'd0);
    chk("reset_done",   {31'd0, done_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk_flags("reset_flags", 3'b000);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1.5 * 2.0
    set_ops(1'b0, 8'd127, 24'hC00000, 1'b0, 8'd128, 24'h800000);
    run_op(lat);
    chk("mul_1p5x2_result", result_o, 32'h4040_0000);
    chk("mul_1p5x2_latency", 32'(lat), 32'd26);
    chk_flags("mul_1p5x2_flags", 3'b000);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done_o}, 32'd0);
    chk("idle_after_done", {31'd0, busy_o}, 32'd0);

    // -1.0 * 1.0, started in the first IDLE cycle after DONE
    set_ops(1'b1, 8'd127, 24'h800000, 1'b0, 8'd127, 24'h800000);
    run_op(lat);
    chk("neg_one_result", result_o, 32'hBF80_0000);
    chk("neg_one_latency", 32'(lat), 32'd26);
    @(posedge clk); #1;

    // Max mantissas: guard 0, sticky 1, no round-up
    set_ops(1'b0, 8'd127, 24'hFFFFFF, 1'b0, 8'd127, 24'hFFFFFF);
    run_op(lat);
    chk("max_mant_result", result_o, 32'h407F_FFFE);
    @(posedge clk); #1;

    // Exact tie with odd LSB rounds up to even
    set_ops(1'b0, 8'd127, 24'h800001, 1'b0, 8'd127, 24'hC00000);
    run_op(lat);
    chk("tie_round_result", result_o, 32'h3FC0_0002);
    @(posedge clk); #1;

    set_ops(1'b0, 8'd254, 24'h800000, 1'b0, 8'd254, 24'h800000);
    run_op(lat);
    chk("overflow_result", result_o, 32'h7F80_0000);
    chk_flags("overflow_flags", 3'b100);
    @(posedge clk); #1;

    set_ops(1'b0, 8'd1, 24'h800000, 1'b0, 8'd1, 24'h800000);
    run_op(lat);
    chk("underflow_result", result_o, 32'h0000_0000);
    chk_flags("underflow_flags", 3'b010);
    @(posedge clk); #1;

    // inf * 0
    set_ops(1'b0, 8'd255, 24'h800000, 1'b0, 8'd0, 24'd0);
    run_op(lat);
    chk("inf_zero_result", result_o, 32'h7FC0_0000);
    chk("inf_zero_latency", 32'(lat), 32'd1);
    chk_flags("inf_zero_flags", 3'b001);
    @(posedge clk); #1;

    // -inf * 2.0
    set_ops(1'b1, 8'd255, 24'h800000, 1'b0, 8'd128, 24'h800000);
    run_op(lat);
    chk("inf_fin_result", result_o, 32'hFF80_0000);
    chk_flags("inf_fin_flags", 3'b000);
    @(posedge clk); #1;

    // -0 * 2.0
    set_ops(1'b1, 8'd0, 24'd0, 1'b0, 8'd128, 24'h800000);
    run_op(lat);
    chk("zero_fin_result", result_o, 32'h8000_0000);
    chk_flags("zero_fin_flags", 3'b000);
    @(posedge clk); #1;

    // NaN * 1.0
    set_ops(1'b0, 8'd255, 24'hC00000, 1'b0, 8'd127, 24'h800000);
    run_op(lat);
    chk("nan_result", result_o, 32'h7FC0_0000);
    chk_flags("nan_flags", 3'b001);
    @(posedge clk); #1;

    // Second start during MUL must be ignored
    set_ops(1'b0, 8'd127, 24'hC00000, 1'b0, 8'd128, 24'h800000);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    set_ops(1'b1, 8'd100, 24'hFFFFFF, 1'b0, 8'd140, 24'hA00000);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 6;
    while (!done_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ignore_start_result", result_o, 32'h4040_0000);
    chk("ignore_start_latency", 32'(lat), 32'd26);
    @(posedge clk); #1;

    // Reset during MUL cycle 10 aborts without done_o
    set_ops(1'b1, 8'd127, 24'h800000, 1'b0, 8'd127, 24'h800000);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    chk("abort_result", result_o, 32'd0);
    chk_flags("abort_flags", 3'b000);
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done_o) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);

    set_ops(1'b0, 8'd127, 24'hC00000, 1'b0, 8'd128, 24'h800000);
    run_op(lat);
    chk("post_abort_result", result_o, 32'h4040_0000);
    chk("post_abort_latency", 32'(lat), 32'd26);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_iter.md
FP_MUL_ITER -- requirements
Module: fp_mul_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start_i, input, 1 bit: operand-valid strobe, sampled only in IDLE.
REQ-004 SHALL have ports signA_i and signB_i, input, 1 bit each: operand signs from the unpack stage.
REQ-005 SHALL have ports expA_i and expB_i, input, 8 bits each: biased exponents.
REQ-006 SHALL have ports mantA_i and mantB_i, input, 24 bits each: mantissas with the hidden bit already inserted (bit 23 = 0 when exponent = 0).
REQ-007 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done_o, output, 1 bit: one-cycle pulse marking result_o and the flags valid.
REQ-009 SHALL have port result_o, output, 32 bits: packed IEEE-754 single-precision product, held until the next done_o.
REQ-010 SHALL have ports overflow_o, underflow_o and invalid_o, output, 1 bit each: exception flags, updated together with done_o.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, NORM and DONE.
REQ-012 SHALL transition IDLE->MUL on start_i=1 with non-special operands, latching all operand inputs.
REQ-013 SHALL transition IDLE->DONE on start_i=1 with special operands, i.e. either exponent is 0 or 255.
REQ-014 SHALL perform 24 MUL cycles of radix-2 shift-add into a 48-bit product P, using a 5-bit counter, then go MUL->NORM.
REQ-015 SHALL compute the exponent in NORM as E = expA + expB - 127 in 10-bit signed arithmetic.
REQ-016 SHALL normalize in NORM as follows: if P[47] is set, fraction = P[46:24], guard = P[23], sticky = OR(P[22:0]) and E is incremented by 1; otherwise fraction = P[45:23], guard = P[22], sticky = OR(P[21:0]).
REQ-017 SHALL round to nearest even: increment the fraction when guard & (sticky | fraction[0]); a fraction carry-out sets the fraction to 0 and increments E by 1.
REQ-018 SHALL produce signed infinity and overflow_o=1 when E >= 255 after rounding.
REQ-019 SHALL produce signed zero and underflow_o=1 when E <= 0 after rounding (flush to zero, no denormal output).
REQ-020 SHALL set the result sign to signA ^ signB for all non-NaN results.
REQ-021 SHALL handle specials as follows: an operand with exponent 0 is treated as zero (denormals flushed); inf*0 or any NaN operand gives 0x7FC00000 with invalid_o=1; inf*finite-nonzero or inf*inf gives signed infinity with no flag; zero*finite gives signed zero with no flag.
REQ-022 SHALL register result_o and the flags on NORM->DONE, or on IDLE->DONE for specials.
REQ-023 SHALL hold done_o=1 for exactly the DONE cycle, then go DONE->IDLE unconditionally.
REQ-024 SHALL have a latency from the start_i sampling edge to the done_o cycle of 26 cycles for normal operands and 1 cycle for specials.
REQ-025 SHALL ignore start_i while busy_o=1 (no queueing, latched operands unchanged).
REQ-026 SHALL accept a new start_i in the first IDLE cycle after DONE (back-to-back throughput of 27 cycles).

Reset
REQ-027 SHALL on rst=1 at a clock edge force state to IDLE, clear the counter and P, and drive busy_o=0, done_o=0, result_o=0 and all flags to 0.
REQ-028 SHALL on reset asserted mid-operation (MUL, NORM or DONE) abort the operation without any done_o pulse.
REQ-029 SHALL give rst priority over start_i in the same cycle.

Structure
REQ-030 SHALL take BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000 and the FSM state enum from the shared package fpu_pkg.
REQ-031 SHALL place normalize/round/pack (REQ-015..REQ-020) in one combinational sub-module fp_round_pack; the FSM and the multiplier datapath stay in fp_mul_iter.

Verification
REQ-032 SHALL be covered by: 1.5*2.0 (exp 127/mant 0xC00000, exp 128/mant 0x800000) -> result 0x40400000, done_o 26 cycles after start, all flags 0.
REQ-033 SHALL be covered by: (-1.0)*1.0 -> 0xBF800000; and mantA=mantB=0xFFFFFF, exp 127 both -> 0x407FFFFE (guard 0, sticky 1, no round-up).
REQ-034 SHALL be covered by: exp 254 * exp 254, both mant 0x800000 -> 0x7F800000, overflow_o=1; exp 1 * exp 1 -> 0x00000000, underflow_o=1.
REQ-035 SHALL be covered by: exp 255/mant 0x800000 * exp 0/mant 0 -> 0x7FC00000, invalid_o=1, done_o 1 cycle after start.
REQ-036 SHALL be covered by: start_i pulsed again during MUL with different operands -> ignored, first result returned unchanged.
REQ-037 SHALL be covered by: rst asserted during MUL cycle 10 -> IDLE next cycle, no done_o, outputs 0, next start completes normally.
